// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the AAI_CPU instruction-fetch sequencer.
// Redirect causes are numbered so that a smaller code means a more urgent redirect.
package pc_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_EXC    = 3'd1,
        CAUSE_ERET   = 3'd2,
        CAUSE_JUMP   = 3'd3,
        CAUSE_BRANCH = 3'd4
    } redirect_cause_t;

    // True when cand is a real redirect at least as urgent as the one already held.
    function automatic logic outranks(input redirect_cause_t cand, input redirect_cause_t held);
        return (cand != CAUSE_NONE) && ((held == CAUSE_NONE) || (cand <= held));
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority selection of the redirect cause and its target for the fetch unit.
// Misaligned targets are replaced by the exception vector and flagged.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic            stall,
    input  logic            exc_req,
    input  logic            eret,
    input  logic [31:0]     epc_in,
    input  logic            jump,
    input  logic [31:0]     jump_target,
    input  logic            branch_taken,
    input  logic [31:0]     branch_target,
    output redirect_cause_t cause,
    output logic [31:0]     target,
    output logic            misalign
);

    logic [31:0] raw_target;

    always_comb begin
        cause      = CAUSE_NONE;
        raw_target = EXC_VECTOR;
        // Exceptions bypass the stall; all other redirects wait for an unfrozen pipeline.
        if (exc_req) begin
            cause      = CAUSE_EXC;
            raw_target = EXC_VECTOR;
        end else if (!stall) begin
            if (eret) begin
                cause      = CAUSE_ERET;
                raw_target = epc_in;
            end else if (jump) begin
                cause      = CAUSE_JUMP;
                raw_target = jump_target;
            end else if (branch_taken) begin
                cause      = CAUSE_BRANCH;
                raw_target = branch_target;
            end
        end
    end

    assign misalign = (cause != CAUSE_NONE) && (raw_target[1:0] != 2'b00);
    assign target   = misalign ? EXC_VECTOR : raw_target;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer driving the IF/ID register.
// A redirect arriving while a request is in flight is parked until that request completes.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        eret,
    input  logic [31:0] epc_in,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    fetch_state_t    state_reg, state_next;
    logic [31:0]     pc_reg, pc_next;
    redirect_cause_t pend_cause_reg, pend_cause_next;
    logic [31:0]     pend_target_reg, pend_target_next;
    logic [31:0]     hold_reg, hold_next;
    logic [31:0]     inst_reg, inst_next;
    logic [31:0]     pc_out_reg, pc_out_next;
    logic [31:0]     plus4_reg, plus4_next;
    logic            valid_reg, valid_next;
    logic            fault_reg, fault_next;

    redirect_cause_t sel_cause;
    logic [31:0]     sel_target;
    logic            sel_misalign;
    logic            ack;
    logic            accept;
    logic            discarding;
    logic [31:0]     redir_target;
    logic            deliver;
    logic [31:0]     deliver_data;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .stall         (stall),
        .exc_req       (exc_req),
        .eret          (eret),
        .epc_in        (epc_in),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .cause         (sel_cause),
        .target        (sel_target),
        .misalign      (sel_misalign)
    );

    assign imem_req  = ((state_reg == S_FETCH) && !stall) || (state_reg == S_WAIT);
    assign imem_addr = pc_reg;
    assign ack       = imem_ack && imem_req;

    // A parked redirect is only displaced by one at least as urgent.
    assign accept       = outranks(sel_cause, pend_cause_reg);
    assign discarding   = (pend_cause_reg != CAUSE_NONE) || accept;
    assign redir_target = accept ? sel_target : pend_target_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_cause_next  = pend_cause_reg;
        pend_target_next = pend_target_reg;
        hold_next        = hold_reg;
        inst_next        = inst_reg;
        pc_out_next      = pc_out_reg;
        plus4_next       = plus4_reg;
        fault_next       = accept && sel_misalign;
        deliver          = 1'b0;
        deliver_data     = imem_rdata;

        case (state_reg)
            S_BOOT: begin
                state_next = S_FETCH;
                if (accept) begin
                    pc_next = sel_target;
                end
            end
            S_FETCH, S_WAIT: begin
                if (imem_req) begin
                    if (ack) begin
                        if (discarding) begin
                            pc_next         = redir_target;
                            pend_cause_next = CAUSE_NONE;
                            state_next      = S_FETCH;
                        end else if (!stall) begin
                            deliver    = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            hold_next  = imem_rdata;
                            state_next = S_HOLD;
                        end
                    end else begin
                        // The request must stay up until acked, so a redirect is parked.
                        state_next = S_WAIT;
                        if (accept) begin
                            pend_cause_next  = sel_cause;
                            pend_target_next = sel_target;
                        end
                    end
                end else if (accept) begin
                    pc_next = sel_target;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    pc_next    = sel_target;
                    hold_next  = 32'h0;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_data = hold_reg;
                    state_next   = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase

        if (deliver) begin
            inst_next   = deliver_data;
            pc_out_next = pc_reg;
            plus4_next  = pc_reg + 32'd4;
            pc_next     = pc_reg + 32'd4;
        end

        if (accept) begin
            valid_next = 1'b0;
        end else if (deliver) begin
            valid_next = 1'b1;
        end else if (stall) begin
            valid_next = valid_reg;
        end else begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_BOOT;
            pc_reg          <= RESET_VECTOR;
            pend_cause_reg  <= CAUSE_NONE;
            pend_target_reg <= 32'h0;
            hold_reg        <= 32'h0;
            inst_reg        <= 32'h0;
            pc_out_reg      <= 32'h0;
            plus4_reg       <= 32'd4;
            valid_reg       <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_cause_reg  <= pend_cause_next;
            pend_target_reg <= pend_target_next;
            hold_reg        <= hold_next;
            inst_reg        <= inst_next;
            pc_out_reg      <= pc_out_next;
            plus4_reg       <= plus4_next;
            valid_reg       <= valid_next;
            fault_reg       <= fault_next;
        end
    end

    assign inst_out    = inst_reg;
    assign pc_out      = pc_out_reg;
    assign pc_plus4    = plus4_reg;
    assign inst_valid  = valid_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized run checked against
// an architectural model of the expected instruction stream.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, eret, exc_req, imem_ack;
    logic [31:0] branch_target, jump_target, epc_in;
    logic        imem_req, inst_valid, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, inst_out, pc_out, pc_plus4;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] EXC_VEC = 32'h0000_0180;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .eret(eret), .epc_in(epc_in), .exc_req(exc_req),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
        .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; eret = 0; exc_req = 0; imem_ack = 0;
        branch_target = 0; jump_target = 0; epc_in = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        imem_ack = 1'b1;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        total++; if (inst_out !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL reset_regs: inst %h pc %h want 0 0", inst_out, pc_out); end
        total++; if (inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_flags: valid %b fault %b want 0 0", inst_valid, fetch_fault); end
        total++; if (pc_plus4 !== 32'd4) begin bad++; $display("FAIL reset_plus4: got %h want 4", pc_plus4); end
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
        $display("reset: checked reset values and boot cycle");
    endtask

    task automatic test_sequential();
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL first_req: req %b addr %h valid %b want 1 0 0", imem_req, imem_addr, inst_valid); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = 32'(4 * k);
            tick();
            total++; if (inst_valid !== 1'b1 || pc_out !== e || inst_out !== mem_word(e) || pc_plus4 !== e + 32'd4) begin
                bad++; $display("FAIL seq_%0d: valid %b pc %h inst %h plus4 %h want pc %h", k, inst_valid, pc_out, inst_out, pc_plus4, e); end
            $display("sequential: pc_out=%h inst_valid=%b", pc_out, inst_valid);
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        imem_ack = 1'b1;
        tick(); tick(); tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                bad++; $display("FAIL delay_bubble_%0d: valid %b req %b addr %h want 0 1 8", k, inst_valid, imem_req, imem_addr); end
        end
        imem_ack = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h8 || inst_out !== mem_word(32'h8)) begin
            bad++; $display("FAIL delay_deliver: valid %b pc %h want 1 8", inst_valid, pc_out); end
        $display("ack_delay: delivered pc_out=%h after two bubbles", pc_out);
    endtask

    task automatic test_jump_wait();
        tick();
        imem_ack = 1'b0;
        tick();
        jump = 1'b1; jump_target = 32'h100;
        tick();
        jump = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                bad++; $display("FAIL jump_wait_%0d: valid %b req %b addr %h want 0 1 10", k, inst_valid, imem_req, imem_addr); end
            if (k == 0) tick();
        end
        imem_ack = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL jump_discard: valid %b pc %h want valid 0", inst_valid, pc_out); end
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== mem_word(32'h100)) begin
            bad++; $display("FAIL jump_target: valid %b pc %h want 1 100", inst_valid, pc_out); end
        $display("jump_wait: first valid pc_out=%h", pc_out);
    endtask

    task automatic test_stall_hold();
        jump = 1'b1; jump_target = 32'h20;
        tick();
        jump = 1'b0; imem_ack = 1'b0;
        tick();
        stall = 1'b1; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (pc_out !== 32'h100 || inst_out !== mem_word(32'h100) || inst_valid !== 1'b0 || pc_plus4 !== 32'h104 || imem_req !== 1'b0) begin
                bad++; $display("FAIL hold_frozen_%0d: pc %h valid %b plus4 %h req %b want 100 0 104 0", k, pc_out, inst_valid, pc_plus4, imem_req); end
            tick();
        end
        stall = 1'b0; imem_ack = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h20 || inst_out !== mem_word(32'h20)) begin
            bad++; $display("FAIL hold_release: valid %b pc %h inst %h want 1 20", inst_valid, pc_out, inst_out); end
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h24) begin bad++; $display("FAIL hold_next: valid %b pc %h want 1 24", inst_valid, pc_out); end
        stall = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h24 || pc_plus4 !== 32'h28) begin
            bad++; $display("FAIL stall_freeze: valid %b pc %h plus4 %h want 1 24 28", inst_valid, pc_out, pc_plus4); end
        $display("stall_hold: buffered word released at pc_out=20");
    endtask

    task automatic test_exc_stall();
        exc_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        total++; if (inst_valid !== 1'b0 || pc_out !== 32'h24 || fetch_fault !== 1'b0) begin
            bad++; $display("FAIL exc_flush: valid %b pc %h fault %b want 0 24 0", inst_valid, pc_out, fetch_fault); end
        exc_req = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== EXC_VEC) begin bad++; $display("FAIL exc_target: valid %b pc %h want 1 180", inst_valid, pc_out); end
        $display("exc_stall: pc_out=%h", pc_out);
    endtask

    task automatic test_misalign();
        branch_taken = 1'b1; branch_target = 32'h102;
        tick();
        total++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL misalign_pulse: fault %b valid %b want 1 0", fetch_fault, inst_valid); end
        branch_taken = 1'b0;
        tick();
        total++; if (fetch_fault !== 1'b0 || inst_valid !== 1'b1 || pc_out !== EXC_VEC) begin
            bad++; $display("FAIL misalign_target: fault %b valid %b pc %h want 0 1 180", fetch_fault, inst_valid, pc_out); end
        $display("misalign: fault pulsed, pc_out=%h", pc_out);
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 32'hFFFF_FFF8;
        tick();
        jump = 1'b0;
        tick();
        total++; if (pc_out !== 32'hFFFF_FFF8 || inst_valid !== 1'b1) begin bad++; $display("FAIL wrap_a: pc %h want fffffff8", pc_out); end
        tick();
        total++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_b: pc %h plus4 %h want fffffffc 0", pc_out, pc_plus4); end
        tick();
        total++; if (pc_out !== 32'h0 || inst_valid !== 1'b1 || inst_out !== mem_word(32'h0)) begin bad++; $display("FAIL wrap_c: pc %h valid %b want 0 1", pc_out, inst_valid); end
        $display("wrap: pc_out=%h after fffffffc", pc_out);
    endtask

    task automatic test_reset_abort();
        imem_ack = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL abort_async: req %b addr %h valid %b want 0 0 0", imem_req, imem_addr, inst_valid); end
        tick();
        rst_n = 1'b1; imem_ack = 1'b1;
        tick();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL abort_late_ack: valid %b want 0", inst_valid); end
        tick();
        total++; if (inst_valid !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL abort_restart: valid %b pc %h want 1 0", inst_valid, pc_out); end
        $display("reset_abort: restarted at pc_out=%h", pc_out);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    // Architectural model: the delivered stream must be consecutive words from the
    // most recent accepted redirect target; a redirect parked behind an in-flight
    // fetch can only be replaced by an equally or more urgent one.
    task automatic test_random();
        logic [31:0] exp_pc, held_addr, prev_inst, prev_pc, prev_plus4, raw, eff;
        logic        disc, held, prev_valid, req_now, ack_eff, accept, mis, was_disc, stall_c;
        int          disc_prio, prio, idle, delivered, redirects;
        do_reset();
        exp_pc = 32'h0; disc = 0; disc_prio = 0; held = 0; held_addr = 0;
        idle = 0; delivered = 0; redirects = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            stall = ($urandom_range(0, 3) == 0);
            exc_req = ($urandom_range(0, 39) == 0);
            eret = ($urandom_range(0, 24) == 0);
            jump = ($urandom_range(0, 19) == 0);
            branch_taken = ($urandom_range(0, 11) == 0);
            epc_in = rand_target(); jump_target = rand_target(); branch_target = rand_target();
            imem_ack = ($urandom_range(0, 9) < 6);
            #1;
            req_now = imem_req;
            if (held) begin
                total++; if (req_now !== 1'b1 || imem_addr !== held_addr) begin
                    bad++; $display("FAIL rnd_req_hold cyc %0d: req %b addr %h want 1 %h", cyc, req_now, imem_addr, held_addr); end
            end
            prio = 0; raw = 32'h0;
            if (exc_req) begin prio = 1; raw = EXC_VEC; end
            else if (!stall && eret) begin prio = 2; raw = epc_in; end
            else if (!stall && jump) begin prio = 3; raw = jump_target; end
            else if (!stall && branch_taken) begin prio = 4; raw = branch_target; end
            mis = (prio != 0) && (raw[1:0] != 2'b00);
            eff = mis ? EXC_VEC : raw;
            ack_eff = imem_ack && req_now;
            accept = (prio != 0) && (!disc || prio <= disc_prio);
            was_disc = disc; stall_c = stall;
            prev_inst = inst_out; prev_pc = pc_out; prev_plus4 = pc_plus4; prev_valid = inst_valid;
            held = req_now && !ack_eff; held_addr = imem_addr;
            tick();
            if (accept) begin exp_pc = eff; redirects++; idle = 0; end
            if (ack_eff) disc = 0;
            else if (req_now && accept) begin disc = 1; disc_prio = prio; end
            total++; if (fetch_fault !== (accept && mis)) begin
                bad++; $display("FAIL rnd_fault cyc %0d: got %b want %b", cyc, fetch_fault, accept && mis); end
            if (accept || (was_disc && !stall_c)) begin
                total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush cyc %0d: valid %b pc %h want valid 0", cyc, inst_valid, pc_out); end
            end else if (stall_c) begin
                total++; if (inst_out !== prev_inst || pc_out !== prev_pc || pc_plus4 !== prev_plus4 || inst_valid !== prev_valid) begin
                    bad++; $display("FAIL rnd_freeze cyc %0d: pc %h valid %b want %h %b", cyc, pc_out, inst_valid, prev_pc, prev_valid); end
            end else if (inst_valid === 1'b1) begin
                total++; if (pc_out !== exp_pc || inst_out !== mem_word(exp_pc) || pc_plus4 !== exp_pc + 32'd4) begin
                    bad++; $display("FAIL rnd_stream cyc %0d: pc %h inst %h plus4 %h want pc %h", cyc, pc_out, inst_out, pc_plus4, exp_pc); end
                exp_pc = exp_pc + 32'd4; idle = 0; delivered++;
            end else begin
                idle++;
                if (idle > 60) begin
                    total++; bad++;
                    $display("FAIL rnd_progress cyc %0d: no instruction for %0d cycles, want at most 60", cyc, idle);
                    break;
                end
            end
        end
        clear_inputs();
        $display("random: delivered=%0d redirects=%0d", delivered, redirects);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_jump_wait();
        test_stall_hold();
        test_exc_stall();
        test_misalign();
        test_wrap();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
